// File: rtl/apb_req_arbiter_master.sv
// Round-robin arbiter and APB master sequencer. NUM_REQ local requesters
// share one APB slave, and only one transfer is outstanding at a time.
//
// state  | meaning
// IDLE   | no transfer in flight; arbitrate among pending requests
// SETUP  | APB setup phase (PSEL=1, PENABLE=0), lasts one cycle
// ACCESS | APB access phase (PSEL=1, PENABLE=1); wait for PREADY or timeout
module apb_req_arbiter_master #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_strb,
    output logic [NUM_REQ-1:0]               req_grant,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [DATA_WIDTH-1:0]            PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      rspv_q, rspv_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;

    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        cand;
    int                      sum;
    logic                    take_grant;

    // Round-robin search: first pending requester starting at last+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        sum       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = int'(last_q) + off;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        grant_d    = '0;
        rspv_d     = '0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        take_grant = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    take_grant = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rspv_d[owner_q] = 1'b1;
                    rdata_d         = pwrite_q ? '0 : PRDATA;
                    err_d           = PSLVERR;
                    if (win_found) begin
                        take_grant = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle without PREADY: abort to IDLE.
                    rspv_d[owner_q] = 1'b1;
                    rdata_d         = '0;
                    err_d           = 1'b1;
                    state_d         = ST_IDLE;
                    psel_d          = 1'b0;
                    penable_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        if (take_grant) begin
            state_d          = ST_SETUP;
            last_d           = win_idx;
            owner_d          = win_idx;
            grant_d[win_idx] = 1'b1;
            cnt_d            = '0;
            psel_d           = 1'b1;
            penable_d        = 1'b0;
            pwrite_d         = req_write[win_idx];
            paddr_d          = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_d         = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            pstrb_d          = req_write[win_idx] ? req_strb[win_idx*STRB_W +: STRB_W] : '0;
        end
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            owner_q   <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            rspv_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            rspv_q    <= rspv_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
        end
    end

    assign req_grant = grant_q;
    assign rsp_valid = rspv_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_req_arbiter_master.sv
// Bench for apb_req_arbiter_master: directed requests against a small APB
// memory slave (64 words, PSLVERR above that), with a response scoreboard.
module tb_apb_req_arbiter_master;

    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic             PCLK;
    logic             PRESETn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*SW-1:0] req_strb;
    logic [NR-1:0]    req_grant;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             PSEL, PENABLE, PWRITE;
    logic [AW-1:0]    PADDR;
    logic [DW-1:0]    PWDATA;
    logic [SW-1:0]    PSTRB;
    logic [DW-1:0]    PRDATA;
    logic             PREADY;
    logic             PSLVERR;

    apb_req_arbiter_master #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_grant(req_grant), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int failures = 0;

    // APB slave model
    logic [DW-1:0] slv_mem [64];
    int            wait_states = 0;
    bit            hang = 1'b0;
    int            wait_cnt = 0;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) wait_cnt <= 0;
        else if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    assign PREADY  = PSEL && PENABLE && !hang && (wait_cnt >= wait_states);
    assign PRDATA  = (PADDR < 8'd64) ? slv_mem[PADDR[5:0]] : '0;
    assign PSLVERR = PSEL && PENABLE && (PADDR >= 8'd64);

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE && PADDR < 8'd64) begin
            for (int b = 0; b < SW; b++)
                if (PSTRB[b]) slv_mem[PADDR[5:0]][b*8 +: 8] <= PWDATA[b*8 +: 8];
        end
    end

    // Scoreboard and reference memory
    typedef struct {
        int            idx;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] ref_mem [64];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input int idx, input bit wr, input logic [7:0] addr,
                              input logic [DW-1:0] wd, input logic [SW-1:0] st);
        exp_t e;
        e.idx   = idx;
        e.err   = (addr >= 8'd64);
        e.rdata = '0;
        if (!wr && addr < 8'd64) e.rdata = ref_mem[addr[5:0]];
        if (wr && addr < 8'd64)
            for (int b = 0; b < SW; b++)
                if (st[b]) ref_mem[addr[5:0]][b*8 +: 8] = wd[b*8 +: 8];
        sb.push_back(e);
    endtask

    // Response monitor: every rsp_valid pulse is matched against the scoreboard.
    always @(negedge PCLK) begin
        if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 128'(rsp_valid), 128'(0));
            end else begin
                exp_t          e;
                logic [NR-1:0] ev;
                e = sb.pop_front();
                ev = '0;
                ev[e.idx] = 1'b1;
                check("rsp_valid", 128'(rsp_valid), 128'(ev));
                check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
                check("rsp_err", 128'(rsp_err), 128'(e.err));
            end
        end
    end

    task automatic set_fields(input int idx, input bit wr, input logic [7:0] addr,
                              input logic [DW-1:0] wd, input logic [SW-1:0] st);
        req_write[idx]         = wr;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*DW +: DW] = wd;
        req_strb[idx*SW +: SW] = st;
    endtask

    task automatic wait_grant(input int idx);
        logic [NR-1:0] ev;
        ev = '0;
        ev[idx] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge PCLK);
            if (req_grant !== '0) break;
        end
        check("grant_idx", 128'(req_grant), 128'(ev));
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0) break;
            @(negedge PCLK);
        end
        check("sb_drain", 128'(sb.size()), 128'(0));
    endtask

    // One request from one requester; reports ACCESS cycle count and stability.
    task automatic run_xfer(input int idx, input bit wr, input logic [7:0] addr,
                            input logic [DW-1:0] wd, input logic [SW-1:0] st,
                            output int acc, output bit stable);
        logic [AW+DW+SW:0] snap;
        set_fields(idx, wr, addr, wd, st);
        req_valid[idx] = 1'b1;
        wait_grant(idx);
        check("setup_phase", 128'({PSEL, PENABLE}), 128'(2'b10));
        check("setup_addr", 128'(PADDR), 128'(addr));
        check("setup_strb", 128'(PSTRB), 128'(wr ? st : 4'h0));
        snap = {PWRITE, PADDR, PWDATA, PSTRB};
        @(posedge PCLK);
        #1 req_valid[idx] = 1'b0;
        acc = 0;
        stable = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge PCLK);
            if (rsp_valid !== '0) break;
            if (PENABLE) begin
                acc++;
                if ({PWRITE, PADDR, PWDATA, PSTRB} !== snap || !PSEL) stable = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        bit  stab;
        int  gcount, last_g, cyc, pslow;
        int  gcnt[NR];
        bit  started;
        logic [NR-1:0] drop, ev;

        for (int i = 0; i < 64; i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        PRESETn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;

        // Contention: both requesters valid from reset, four transfers each.
        set_fields(0, 1'b1, 8'h10, 32'h1111_2222, 4'hF);
        set_fields(1, 1'b0, 8'h10, 32'h0, 4'hF);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            expect_rsp(0, 1'b1, 8'h10, 32'h1111_2222, 4'hF);
            expect_rsp(1, 1'b0, 8'h10, 32'h0, 4'hF);
        end
        repeat (3) @(negedge PCLK);
        check("reset_outputs",
              {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, req_grant, rsp_valid, rsp_rdata, rsp_err},
              128'(0));
        PRESETn = 1'b1;

        gcount = 0; last_g = 0; cyc = 0; pslow = 0; started = 1'b0;
        gcnt[0] = 0; gcnt[1] = 0;
        for (int n = 0; n < 100 && gcount < 8; n++) begin
            @(negedge PCLK);
            cyc++;
            drop = '0;
            if (started && !PSEL) pslow++;
            if (req_grant !== '0) begin
                ev = '0;
                ev[gcount % 2] = 1'b1;
                check("cont_grant_order", 128'(req_grant), 128'(ev));
                if (gcount > 0) check("cont_grant_gap", 128'(cyc - last_g), 128'(2));
                last_g = cyc;
                started = 1'b1;
                gcount++;
                for (int r = 0; r < NR; r++)
                    if (req_grant[r]) begin
                        gcnt[r]++;
                        if (gcnt[r] == 4) drop[r] = 1'b1;
                    end
            end
            @(posedge PCLK);
            #1 req_valid = req_valid & ~drop;
        end
        check("cont_grant_count", 128'(gcount), 128'(8));
        check("cont_no_idle", 128'(pslow), 128'(0));
        wait_drain();
        check("cont_idle_after", 128'({PSEL, PENABLE}), 128'(0));

        // Single write
        wait_states = 0;
        expect_rsp(0, 1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF);
        run_xfer(0, 1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF, acc, stab);
        check("wr_access_cycles", 128'(acc), 128'(1));
        wait_drain();

        // Read with three wait states
        wait_states = 3;
        expect_rsp(1, 1'b0, 8'h05, 32'h0, 4'hF);
        run_xfer(1, 1'b0, 8'h05, 32'h0, 4'hF, acc, stab);
        check("rd_access_cycles", 128'(acc), 128'(4));
        check("rd_stable", 128'(stab), 128'(1));
        @(negedge PCLK);
        check("rd_single_rsp", 128'(rsp_valid), 128'(0));
        wait_drain();

        // Out-of-range write
        wait_states = 0;
        expect_rsp(0, 1'b1, 8'hFF, 32'h1234_5678, 4'hF);
        run_xfer(0, 1'b1, 8'hFF, 32'h1234_5678, 4'hF, acc, stab);
        check("oor_access_cycles", 128'(acc), 128'(1));
        wait_drain();

        // Timeout with PREADY stuck low
        hang = 1'b1;
        begin
            exp_t e;
            e.idx = 1; e.rdata = '0; e.err = 1'b1;
            sb.push_back(e);
        end
        run_xfer(1, 1'b0, 8'h05, 32'h0, 4'hF, acc, stab);
        check("to_access_cycles", 128'(acc), 128'(TO));
        check("to_bus_released", 128'({PSEL, PENABLE}), 128'(0));
        check("to_stable", 128'(stab), 128'(1));
        wait_drain();
        hang = 1'b0;

        // Reset during a wait state
        hang = 1'b1;
        set_fields(1, 1'b0, 8'h05, 32'h0, 4'hF);
        req_valid[1] = 1'b1;
        wait_grant(1);
        @(posedge PCLK);
        #1 req_valid[1] = 1'b0;
        repeat (4) @(negedge PCLK);
        check("pre_rst_access", 128'({PSEL, PENABLE}), 128'(2'b11));
        #2 PRESETn = 1'b0;
        #1 check("async_rst_outputs",
                 {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, req_grant, rsp_valid, rsp_rdata, rsp_err},
                 128'(0));
        hang = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        check("post_rst_no_rsp", 128'(rsp_valid), 128'(0));

        expect_rsp(0, 1'b0, 8'h05, 32'h0, 4'hF);
        expect_rsp(1, 1'b0, 8'h10, 32'h0, 4'hF);
        set_fields(0, 1'b0, 8'h05, 32'h0, 4'hF);
        set_fields(1, 1'b0, 8'h10, 32'h0, 4'hF);
        req_valid = 2'b11;
        wait_grant(0);
        @(posedge PCLK);
        #1 req_valid[0] = 1'b0;
        wait_grant(1);
        @(posedge PCLK);
        #1 req_valid[1] = 1'b0;
        wait_drain();
        repeat (3) @(negedge PCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter_master.md
Name: apb_req_arbiter_master

Overview:
Round-robin arbiter and APB master sequencer that shares the single APB memory slave among NUM_REQ local requesters. It accepts one request at a time from a valid/grant interface and drives the APB SETUP and ACCESS phases. It waits on PREADY, bounded by a timeout, and returns PRDATA/PSLVERR to the owning requester. It sits between the bus clients and the APB slave (PADDR/PWDATA/PSTRB/PRDATA/PREADY/PSLVERR).

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 8, APB address width
DATA_WIDTH, 32, APB data width; strobe width is DATA_WIDTH/8
TIMEOUT, 16, max ACCESS cycles without PREADY before abort (>=2)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request pending
req_write  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, slice i = requester i
req_wdata  in  NUM_REQ*DATA_WIDTH  per-requester write data
req_strb  in  NUM_REQ*DATA_WIDTH/8  per-requester byte strobes
req_grant  out  NUM_REQ  one-hot, one-cycle pulse: request i latched
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transfer i complete
rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid
rsp_err  out  1  error flag; valid with rsp_valid
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  DATA_WIDTH/8  APB strobes
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Clocking and reset: one clock, PCLK. PRESETn is asynchronous and active-low.
- Reset values: every output is 0. FSM=IDLE. RR pointer last=NUM_REQ-1, so requester 0 wins first. Timeout counter=0.
- Reset mid-transfer: the transfer is abandoned immediately. No rsp_valid is issued for it.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration point: arbitration runs in IDLE, and in ACCESS in the completion cycle.
- Winner selection: the first asserted req_valid[i] scanning from last+1 upward, wrapping modulo NUM_REQ. On the next edge:
  - latch the winner's write/addr/wdata/strb;
  - last<=winner;
  - req_grant[winner]<=1 for exactly one cycle;
  - FSM->SETUP.
- Requester rules: the requester holds valid and fields stable until it samples its grant. A requester may re-assert valid immediately for a new request.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB = latched values. PSTRB is forced to 0 for reads. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1, all address/control/data held stable. The counter increments each cycle PREADY=0.
- ACCESS completion on PREADY=1:
  - rsp_valid[owner]<=1 for one cycle;
  - rsp_rdata<=PRDATA for reads, 0 for writes;
  - rsp_err<=PSLVERR.
  - If any req_valid is asserted, arbitrate and go directly to SETUP; PSEL stays 1 and PENABLE drops to 0. Otherwise go to IDLE with PSEL=0 and PENABLE=0.
- Timeout: if the counter reaches TIMEOUT with PREADY still 0:
  - abort with rsp_valid[owner]<=1, rsp_err<=1, rsp_rdata<=0;
  - PSEL and PENABLE go to 0 on the same edge;
  - FSM->IDLE, never directly to SETUP.
- Counter: clears on every entry to SETUP.
- rsp_rdata and rsp_err hold their last values between pulses.
- APB output stability: PADDR, PWDATA, PSTRB and PWRITE change only on entry to SETUP. They keep their last values while in IDLE.
- Ownership: at most one transfer is outstanding. req_grant and rsp_valid are never asserted for the same requester in the same cycle unless it is a back-to-back re-grant.
- Simultaneous requests: simultaneous requests are served in RR order. A requester that keeps valid high cannot win twice while another requester is waiting.

Test Plan:
- Single write: req0 write addr 0x05, data 0xDEADBEEF, strb 0xF. Required: grant0 pulse, SETUP, then ACCESS with PREADY=1, then rsp_valid[0] with rsp_err=0. The APB phase pattern is PSEL=1,PENABLE=0 then PSEL=1,PENABLE=1.
- Read with wait states: req1 reads 0x05, PREADY held low 3 cycles. Required: PADDR and PWRITE stable through all 4 ACCESS cycles, PSTRB=0, rsp_rdata=0xDEADBEEF, rsp_valid[1] exactly once.
- Contention: req0 and req1 both held valid from reset for 4 transfers each. Required grant order 0,1,0,1,… and back-to-back SETUP with no IDLE cycle between transfers.
- Out-of-range: req0 write to addr 0xFF with depth 64, slave returns PSLVERR=1. Required: rsp_err=1 and rsp_valid[0] in the completion cycle.
- Timeout: PREADY tied 0 with TIMEOUT=16. Required: after 16 ACCESS cycles rsp_valid pulse with rsp_err=1 and rsp_rdata=0, PSEL=0, then IDLE.
- Reset mid-ACCESS: assert PRESETn=0 during a wait state. Required: all outputs 0 asynchronously, no rsp_valid, and the next request after reset is granted to requester 0.
